spike_rate_encoder: RTL and testbench

- Rate-codes one frame of S pixel intensities into T_STEPS binary spike vectors, one vector per clock.
- Sits upstream of the weighted-sum (MAC) stage and drives its S-bit pixel/spike input.
- Default mode is a deterministic per-pixel phase accumulator: a pixel of value p fires floor(p*T_STEPS/2^PIX_W) times per frame.

---
 rtl/spike_rate_encoder.sv | 147 ++++++++++++++
 tb/tb_spike_rate_encoder.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/spike_rate_encoder.sv
// Rate-codes a frame of S pixels into T_STEPS binary spike vectors, one per clock.
// Define ENC_LFSR_EN to replace the phase accumulators with a shared Galois LFSR.
module spike_rate_encoder #(
  parameter int          S         = 25,
  parameter int          PIX_W     = 8,
  parameter int          T_STEPS   = 16,
  parameter logic [15:0] LFSR_SEED = 16'hACE1,
  localparam int         SW        = (T_STEPS > 2) ? $clog2(T_STEPS) : 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               load,
  input  logic [S*PIX_W-1:0] pixels_in,
  input  logic               clear,
  output logic               ready,
  output logic [S-1:0]       spikes_out,
  output logic               spike_valid,
  output logic [SW-1:0]      step_idx,
  output logic               frame_done
);

  if (T_STEPS < 2) begin : g_bad_steps
    $error("T_STEPS must be at least 2");
  end
  if (LFSR_SEED == 16'h0) begin : g_bad_seed
    $error("LFSR_SEED must be non-zero");
  end

  typedef enum logic {IDLE, RUN} state_t;

  state_t           state;
  state_t           state_nxt;
  logic [SW-1:0]    cnt;
  logic             last;
  logic [PIX_W-1:0] pix [S];
  logic [S-1:0]     fire;

  assign ready = (state == IDLE);
  assign last  = (cnt == SW'(T_STEPS - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (clear) begin
      state_nxt = IDLE;
    end else begin
      unique case (state)
        IDLE: if (load) state_nxt = RUN;
        RUN:  if (last) state_nxt = IDLE;
        default: state_nxt = IDLE;
      endcase
    end
  end

`ifdef ENC_LFSR_EN
  logic [15:0] lfsr;
  logic [15:0] lfsr_nxt;
  logic [31:0] rot;

  assign lfsr_nxt = (lfsr >> 1) ^ (lfsr[0] ? 16'hB400 : 16'h0);

  // Each lane compares against its own rotation of the shared LFSR word.
  always_comb begin
    fire = '0;
    rot  = '0;
    for (int k = 0; k < S; k++) begin
      rot = {lfsr, lfsr} << (k % 16);
      fire[S-1-k] = pix[k] > PIX_W'(rot[31:16]);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lfsr <= LFSR_SEED;
    end else if (clear) begin
      lfsr <= LFSR_SEED;
    end else if (state == IDLE) begin
      if (load) lfsr <= LFSR_SEED;
    end else begin
      lfsr <= lfsr_nxt;
    end
  end
`else
  logic [PIX_W-1:0] acc [S];
  logic [PIX_W:0]   sum [S];

  // Carry out of the phase accumulator is the spike.
  always_comb begin
    fire = '0;
    for (int k = 0; k < S; k++) begin
      sum[k] = {1'b0, acc[k]} + {1'b0, pix[k]};
      fire[S-1-k] = sum[k][PIX_W];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < S; k++) acc[k] <= '0;
    end else if (clear) begin
      for (int k = 0; k < S; k++) acc[k] <= '0;
    end else if (state == IDLE) begin
      if (load) begin
        for (int k = 0; k < S; k++) acc[k] <= '0;
      end
    end else begin
      for (int k = 0; k < S; k++) acc[k] <= sum[k][PIX_W-1:0];
    end
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      spikes_out  <= '0;
      spike_valid <= 1'b0;
      step_idx    <= '0;
      frame_done  <= 1'b0;
      cnt         <= '0;
      for (int k = 0; k < S; k++) pix[k] <= '0;
    end else if (clear) begin
      spikes_out  <= '0;
      spike_valid <= 1'b0;
      step_idx    <= '0;
      frame_done  <= 1'b0;
      cnt         <= '0;
    end else if (state == IDLE) begin
      spikes_out  <= '0;
      spike_valid <= 1'b0;
      frame_done  <= 1'b0;
      if (load) begin
        cnt <= '0;
        for (int k = 0; k < S; k++)
          pix[k] <= pixels_in[S*PIX_W-1-PIX_W*k -: PIX_W];
      end
    end else begin
      spikes_out  <= fire;
      spike_valid <= 1'b1;
      step_idx    <= cnt;
      frame_done  <= last;
      cnt         <= last ? '0 : cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_spike_rate_encoder.sv
// Scoreboard bench for spike_rate_encoder: stimulus pushes expected steps,
// a negedge monitor pops and compares each presented spike vector.
module tb_spike_rate_encoder;

  localparam int S  = 25;
  localparam int PW = 8;
  localparam int T  = 16;
  localparam int SW = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          load = 1'b0;
  logic          clear = 1'b0;
  logic [S*PW-1:0] pixels_in = '0;
  logic          ready;
  logic [S-1:0]  spikes_out;
  logic          spike_valid;
  logic [SW-1:0] step_idx;
  logic          frame_done;

  spike_rate_encoder dut (
    .clk(clk), .rst_n(rst_n), .load(load), .pixels_in(pixels_in),
    .clear(clear), .ready(ready), .spikes_out(spikes_out),
    .spike_valid(spike_valid), .step_idx(step_idx), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [S-1:0]  sp;
    logic [SW-1:0] idx;
    logic          done;
  } exp_t;

  int   total = 0;
  int   bad = 0;
  int   cyc = 0;
  exp_t sb[$];
  int   s0[$];
  int   lane_cnt[S];
  int   pm[S];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string n, input logic [63:0] a,
                       input logic [63:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", n, a, e);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_pix(input int a, input int b, input int c, input int d);
    int tbl[4];
    tbl[0] = a; tbl[1] = b; tbl[2] = c; tbl[3] = d;
    for (int k = 0; k < S; k++) begin
      pm[k] = tbl[k % 4];
      pixels_in[S*PW-1-PW*k -: PW] = pm[k][PW-1:0];
    end
  endtask

  // Expected spike for step t: pixel p fires when floor(t*p/256) steps up.
  task automatic push_frame();
    exp_t e;
    logic [15:0] l;
    logic [31:0] r2;
    logic [15:0] r;
    l = 16'hACE1;
    for (int t = 0; t < T; t++) begin
      e = '0;
      for (int k = 0; k < S; k++) begin
`ifdef ENC_LFSR_EN
        r2 = {l, l};
        r = (k % 16 == 0) ? l : 16'((l << (k % 16)) | (l >> (16 - k % 16)));
        e.sp[S-1-k] = (pm[k] > int'(r[7:0]));
`else
        r2 = '0;
        r = '0;
        e.sp[S-1-k] = (((t + 1) * pm[k]) / 256) != ((t * pm[k]) / 256);
`endif
      end
      e.idx  = SW'(t);
      e.done = (t == T - 1);
      sb.push_back(e);
      l = (l >> 1) ^ (l[0] ? 16'hB400 : 16'h0);
    end
  endtask

  task automatic pulse_load();
    load = 1'b1;
    tick();
    load = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 60; i++) begin
      if (sb.size() == 0) break;
      tick();
    end
    check("drain_empty", sb.size(), 0);
    tick();
    tick();
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (rst_n) begin
      if (frame_done && !spike_valid)
        check("done_without_valid", 1, 0);
      if (spike_valid) begin
        if (sb.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_valid: got step %0d want none", step_idx);
        end else begin
          e = sb.pop_front();
          check("spikes", spikes_out, e.sp);
          check("step_idx", step_idx, e.idx);
          check("frame_done", frame_done, e.done);
          if (frame_done) check("ready_at_done", ready, 1);
          if (e.idx == 0) s0.push_back(cyc);
          for (int k = 0; k < S; k++) lane_cnt[k] += int'(spikes_out[S-1-k]);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish want finish");
    $fatal(1);
  end

  initial begin
    #12;
    check("rst_ready", ready, 1);
    check("rst_valid", spike_valid, 0);
    check("rst_spikes", spikes_out, 0);
    check("rst_step", step_idx, 0);
    check("rst_done", frame_done, 0);
    rst_n = 1'b1;
    tick();

    // All 128: odd steps only
    set_pix(128, 128, 128, 128);
    for (int k = 0; k < S; k++) lane_cnt[k] = 0;
    push_frame();
    pulse_load();
    check("ready_low_run", ready, 0);
    drain();
`ifndef ENC_LFSR_EN
    check("cnt128", lane_cnt[0], 8);
`endif

    // Mixed 0/16/64/255
    set_pix(0, 16, 64, 255);
    for (int k = 0; k < S; k++) lane_cnt[k] = 0;
    push_frame();
    pulse_load();
    drain();
`ifndef ENC_LFSR_EN
    check("cnt0", lane_cnt[0], 0);
    check("cnt16", lane_cnt[1], 1);
    check("cnt64", lane_cnt[2], 4);
    check("cnt255", lane_cnt[3], 15);
`endif

    // Back-to-back with load held high; pixels changed mid-run
    set_pix(10, 100, 200, 255);
    s0.delete();
    push_frame();
    load = 1'b1;
    tick();
    set_pix(50, 150, 250, 3);
    check("b2b_ready_run", ready, 0);
    repeat (16) tick();
    check("b2b_ready_end", ready, 1);
    push_frame();
    tick();
    load = 1'b0;
    drain();
    check("b2b_frames", s0.size(), 2);
    if (s0.size() == 2) check("b2b_period", s0[1] - s0[0], 17);

    // Clear together with load at step 5
    set_pix(128, 16, 64, 200);
    push_frame();
    pulse_load();
    repeat (5) tick();
    clear = 1'b1;
    load = 1'b1;
    #6;
    sb.delete();
    tick();
    clear = 1'b0;
    load = 1'b0;
    check("clr_valid", spike_valid, 0);
    check("clr_ready", ready, 1);
    check("clr_done", frame_done, 0);
    check("clr_step", step_idx, 0);
    tick();
    tick();
    check("clr_idle", spike_valid, 0);
    push_frame();
    pulse_load();
    drain();

    // Asynchronous reset mid-frame
    push_frame();
    pulse_load();
    repeat (6) tick();
    #3;
    sb.delete();
    rst_n = 1'b0;
    #1;
    check("arst_spikes", spikes_out, 0);
    check("arst_valid", spike_valid, 0);
    check("arst_done", frame_done, 0);
    check("arst_step", step_idx, 0);
    check("arst_ready", ready, 1);
    #1;
    rst_n = 1'b1;
    repeat (5) tick();
    check("arst_quiet", spike_valid, 0);
    check("arst_ready2", ready, 1);

    // All 0 then all 255 twice
    set_pix(0, 0, 0, 0);
    for (int k = 0; k < S; k++) lane_cnt[k] = 0;
    push_frame();
    pulse_load();
    drain();
    check("zero_cnt", lane_cnt[5], 0);
    set_pix(255, 255, 255, 255);
    push_frame();
    pulse_load();
    drain();
    push_frame();
    pulse_load();
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
